decode_issue: RTL and testbench

DECODE_ISSUE -- requirements
Module: decode_issue

---
 rtl/decode_issue.sv | 207 ++++++++++++++++++++
 tb/tb_decode_issue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// -----------------------------------------------------------------------------
// decode_issue
//
// Single-slot decode and issue stage with a scoreboard-free RAW interlock.
// The instruction waiting in the decode slot is checked against a short shift
// pipe of destination registers still in flight (compute, memory, writeback).
// A match stalls the slot, inserts a bubble toward compute and counts one
// stall cycle. A taken-branch flush squashes the slot. The in-flight pipe
// keeps shifting during a flush.
//
// Parameters
//   PEND_DEPTH   number of in-flight stages tracked for hazards
//   STALL_CNT_W  width of the saturating stall-cycle counter
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   in_valid, in_ir        instruction offered by fetch
//   in_ready               slot can take in_ir this cycle (combinational)
//   flush                  squash the decode slot
//   Rsrc1, Rsrc2           register-file read addresses (combinational)
//   out_valid ... out_imm  registered issue packet toward compute
//   stall_count            saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module decode_issue #(
    parameter int unsigned PEND_DEPTH  = 3,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [31:0]            in_ir,
    output logic                   in_ready,
    input  logic                   flush,
    output logic [4:0]             Rsrc1,
    output logic [4:0]             Rsrc2,
    output logic                   out_valid,
    output logic [5:0]             out_opcode,
    output logic [4:0]             out_rdst,
    output logic                   out_rd_we,
    output logic                   out_use_imm,
    output logic [31:0]            out_imm,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // Decode slot
    logic [31:0] ir_q,       ir_d;
    logic        ir_valid_q, ir_valid_d;

    // In-flight destination tracker
    logic [PEND_DEPTH-1:0] pend_valid_q, pend_valid_d;
    logic [4:0]            pend_dst_q [PEND_DEPTH];
    logic [4:0]            pend_dst_d [PEND_DEPTH];

    // Issue packet
    logic        out_valid_q,   out_valid_d;
    logic [5:0]  out_opcode_q,  out_opcode_d;
    logic [4:0]  out_rdst_q,    out_rdst_d;
    logic        out_rd_we_q,   out_rd_we_d;
    logic        out_use_imm_q, out_use_imm_d;
    logic [31:0] out_imm_q,     out_imm_d;

    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    // Field decode of the held instruction
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [4:0]  dst;
    logic [10:0] imm11;
    logic [5:0]  opcode;
    logic        writes_reg;
    logic        uses_src2;
    logic [31:0] imm_sext;

    logic hazard;
    logic issue;
    logic accept;
    logic stall;

    always_comb begin
        src1       = ir_q[31:27];
        src2       = ir_q[26:22];
        dst        = ir_q[21:17];
        imm11      = ir_q[16:6];
        opcode     = ir_q[5:0];
        writes_reg = !opcode[5] && (dst != '0);
        uses_src2  = !opcode[4];
        imm_sext   = {{21{imm11[10]}}, imm11};
    end

    // The register file read is combinational and happens before the
    // writeback-stage write lands, so the writeback entry (last pend slot)
    // must still be compared like every other in-flight entry.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < PEND_DEPTH; i++) begin
            if (pend_valid_q[i]) begin
                if ((src1 != '0) && (pend_dst_q[i] == src1)) begin
                    hazard = 1'b1;
                end
                if (uses_src2 && (src2 != '0) && (pend_dst_q[i] == src2)) begin
                    hazard = 1'b1;
                end
            end
        end
        hazard = hazard && ir_valid_q;
    end

    always_comb begin
        issue    = ir_valid_q && !hazard && !flush;
        stall    = ir_valid_q && hazard && !flush;
        in_ready = !flush && (!ir_valid_q || issue);
        accept   = in_valid && in_ready;
    end

    // Decode slot next state. in_ready is low under flush, so accept and
    // flush never coincide.
    always_comb begin
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        if (flush) begin
            ir_valid_d = 1'b0;
        end else if (accept) begin
            ir_d       = in_ir;
            ir_valid_d = 1'b1;
        end else if (issue) begin
            ir_valid_d = 1'b0;
        end
    end

    // In-flight pipe shifts every cycle, including stall and flush cycles.
    always_comb begin
        pend_valid_d    = '0;
        pend_dst_d[0]   = dst;
        pend_valid_d[0] = issue && writes_reg;
        for (int unsigned i = 1; i < PEND_DEPTH; i++) begin
            pend_valid_d[i] = pend_valid_q[i-1];
            pend_dst_d[i]   = pend_dst_q[i-1];
        end
    end

    // Packet fields hold their last value across bubbles; only out_valid drops.
    always_comb begin
        out_valid_d   = issue;
        out_opcode_d  = out_opcode_q;
        out_rdst_d    = out_rdst_q;
        out_rd_we_d   = out_rd_we_q;
        out_use_imm_d = out_use_imm_q;
        out_imm_d     = out_imm_q;
        if (issue) begin
            out_opcode_d  = opcode;
            out_rdst_d    = dst;
            out_rd_we_d   = writes_reg;
            out_use_imm_d = opcode[4];
            out_imm_d     = imm_sext;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q          <= '0;
            ir_valid_q    <= 1'b0;
            pend_valid_q  <= '0;
            for (int unsigned i = 0; i < PEND_DEPTH; i++) begin
                pend_dst_q[i] <= '0;
            end
            out_valid_q   <= 1'b0;
            out_opcode_q  <= '0;
            out_rdst_q    <= '0;
            out_rd_we_q   <= 1'b0;
            out_use_imm_q <= 1'b0;
            out_imm_q     <= '0;
            stall_count_q <= '0;
        end else begin
            ir_q          <= ir_d;
            ir_valid_q    <= ir_valid_d;
            pend_valid_q  <= pend_valid_d;
            for (int unsigned i = 0; i < PEND_DEPTH; i++) begin
                pend_dst_q[i] <= pend_dst_d[i];
            end
            out_valid_q   <= out_valid_d;
            out_opcode_q  <= out_opcode_d;
            out_rdst_q    <= out_rdst_d;
            out_rd_we_q   <= out_rd_we_d;
            out_use_imm_q <= out_use_imm_d;
            out_imm_q     <= out_imm_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign Rsrc1       = src1;
    assign Rsrc2       = src2;
    assign out_valid   = out_valid_q;
    assign out_opcode  = out_opcode_q;
    assign out_rdst    = out_rdst_q;
    assign out_rd_we   = out_rd_we_q;
    assign out_use_imm = out_use_imm_q;
    assign out_imm     = out_imm_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_decode_issue.sv
// -----------------------------------------------------------------------------
// tb_decode_issue
//
// Bench for decode_issue. Accepted instructions are decoded by the bench into
// an expected packet queue; every out_valid pops and compares one packet.
// Directed sequences check stall timing, flush, reset and immediate handling.
// -----------------------------------------------------------------------------
module tb_decode_issue;

    localparam int unsigned PEND_DEPTH  = 3;
    localparam int unsigned STALL_CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic [31:0]            in_ir;
    logic                   in_ready;
    logic                   flush;
    logic [4:0]             Rsrc1;
    logic [4:0]             Rsrc2;
    logic                   out_valid;
    logic [5:0]             out_opcode;
    logic [4:0]             out_rdst;
    logic                   out_rd_we;
    logic                   out_use_imm;
    logic [31:0]            out_imm;
    logic [STALL_CNT_W-1:0] stall_count;

    decode_issue #(
        .PEND_DEPTH  (PEND_DEPTH),
        .STALL_CNT_W (STALL_CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ir       (in_ir),
        .in_ready    (in_ready),
        .flush       (flush),
        .Rsrc1       (Rsrc1),
        .Rsrc2       (Rsrc2),
        .out_valid   (out_valid),
        .out_opcode  (out_opcode),
        .out_rdst    (out_rdst),
        .out_rd_we   (out_rd_we),
        .out_use_imm (out_use_imm),
        .out_imm     (out_imm),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [44:0] exp_q [$];
    logic        r;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] s1, input logic [4:0] s2,
                                       input logic [4:0] d, input logic [10:0] imm,
                                       input logic [5:0] op);
        return {s1, s2, d, imm, op};
    endfunction

    // Packet layout: {opcode, rdst, rd_we, use_imm, imm}
    function automatic logic [44:0] expect_pkt(input logic [31:0] ir);
        logic [5:0]  op;
        logic [4:0]  d;
        logic [10:0] imm;
        logic        we;
        op  = ir[5:0];
        d   = ir[21:17];
        imm = ir[16:6];
        we  = (op[5] == 1'b0) && (d != 5'd0);
        return {op, d, we, op[4], {{21{imm[10]}}, imm}};
    endfunction

    // Called at posedge+1: drive inputs, sample in_ready mid-cycle, step.
    task automatic drive(input logic v, input logic [31:0] ir, input logic fl, output logic rdy);
        in_valid = v;
        in_ir    = ir;
        flush    = fl;
        #3;
        rdy = in_ready;
        if (v && rdy) exp_q.push_back(expect_pkt(ir));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
                check("pkt", {out_opcode, out_rdst, out_rd_we, out_use_imm, out_imm},
                      exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_ir    = '0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_stall", stall_count, 0);
        check("rst_imm", out_imm, 0);
        check("rst_fields", {out_opcode, out_rdst, out_rd_we, out_use_imm}, 0);
        check("rst_rsrc", {Rsrc1, Rsrc2}, 0);
        reset = 1'b0;
        #3;
        check("rst_rdy", in_ready, 1);
        @(posedge clk);
        #1;

        // Reset during a RAW stall with two stall cycles counted
        drive(1, mk(1, 2, 3, 0, 6'h00), 0, r);
        check("e_acc", r, 1);
        check("e_rsrc", {Rsrc1, Rsrc2}, {5'd1, 5'd2});
        drive(1, mk(3, 4, 5, 0, 6'h00), 0, r);
        check("e_rdy_t", r, 1);
        check("e_ov_i1", out_valid, 1);
        check("e_rsrc1_i2", Rsrc1, 3);
        repeat (2) begin
            drive(0, '0, 0, r);
            check("e_rdy_stall", r, 0);
            check("e_ov_bubble", out_valid, 0);
        end
        check("e_stall2", stall_count, 2);
        #2 reset = 1'b1;
        #1;
        check("e_rst_stall", stall_count, 0);
        check("e_rst_ov", out_valid, 0);
        check("e_rst_fields", {out_opcode, out_rdst, out_rd_we, out_use_imm, out_imm}, 0);
        check("e_rst_rsrc", {Rsrc1, Rsrc2}, 0);
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, '0, 0, r);
        check("e_rdy_after", r, 1);
        check("e_no_issue", out_valid, 0);
        check("e_stall_after", stall_count, 0);

        // Back-to-back independent instructions
        drive(1, mk(1, 2, 3, 0, 6'h00), 0, r);
        check("a_acc1", r, 1);
        drive(1, mk(4, 5, 6, 0, 6'h00), 0, r);
        check("a_acc2", r, 1);
        check("a_ov1", out_valid, 1);
        drive(0, '0, 0, r);
        check("a_ov2", out_valid, 1);
        drive(0, '0, 0, r);
        check("a_ov3", out_valid, 0);
        check("a_stall", stall_count, 0);
        repeat (3) drive(0, '0, 0, r);

        // RAW on src1: three stall cycles
        drive(1, mk(1, 2, 3, 0, 6'h00), 0, r);
        drive(1, mk(3, 0, 7, 0, 6'h00), 0, r);
        check("b_rdy_t", r, 1);
        check("b_ov_i1", out_valid, 1);
        repeat (3) begin
            drive(0, '0, 0, r);
            check("b_rdy_stall", r, 0);
            check("b_ov_bubble", out_valid, 0);
        end
        drive(0, '0, 0, r);
        check("b_rdy_issue", r, 1);
        check("b_ov_i2", out_valid, 1);
        check("b_stall3", stall_count, 3);
        repeat (3) drive(0, '0, 0, r);

        // r0 destination / r0 source: no stall, no write enable
        drive(1, mk(1, 2, 0, 0, 6'h00), 0, r);
        drive(1, mk(0, 9, 4, 0, 6'h00), 0, r);
        check("c_r0_rdy", r, 1);
        check("c_r0_ov", out_valid, 1);
        check("c_r0_we", out_rd_we, 0);
        drive(0, '0, 0, r);
        check("c_r0_nostall", r, 1);
        check("c_r0_ov2", out_valid, 1);

        // Immediate form ignores src2
        drive(1, mk(1, 2, 5, 0, 6'h00), 0, r);
        drive(1, mk(6, 5, 7, 0, 6'h10), 0, r);
        check("c_imm_rdy", r, 1);
        drive(0, '0, 0, r);
        check("c_imm_nostall", r, 1);
        check("c_imm_ov", out_valid, 1);
        check("c_imm_use", out_use_imm, 1);
        check("c_stall", stall_count, 3);

        // Immediate sign extension boundaries
        drive(1, mk(0, 0, 0, 11'h3FF, 6'h10), 0, r);
        drive(1, mk(0, 0, 0, 11'h400, 6'h10), 0, r);
        check("s_rdy", r, 1);
        check("s_imm_pos", out_imm, 32'h0000_03FF);
        drive(0, '0, 0, r);
        check("s_imm_neg", out_imm, 32'hFFFF_FC00);

        // opcode[5] set: no register write, so no hazard for a reader
        drive(1, mk(1, 2, 8, 0, 6'h20), 0, r);
        drive(1, mk(8, 0, 9, 0, 6'h00), 0, r);
        check("o_rdy", r, 1);
        check("o_we", out_rd_we, 0);
        drive(0, '0, 0, r);
        check("o_nostall", r, 1);
        check("o_ov", out_valid, 1);
        repeat (3) drive(0, '0, 0, r);

        // Flush during a RAW stall; pend keeps draining
        drive(1, mk(1, 2, 3, 0, 6'h00), 0, r);
        drive(1, mk(3, 4, 5, 0, 6'h00), 0, r);
        check("d_rdy_t", r, 1);
        drive(0, '0, 0, r);
        check("d_rdy_stall", r, 0);
        check("d_stall4", stall_count, 4);
        drive(1, mk(10, 11, 12, 0, 6'h00), 1, r);
        void'(exp_q.pop_back());
        check("d_rdy_flush", r, 0);
        check("d_ov_flush", out_valid, 0);
        check("d_stall_flush", stall_count, 4);
        drive(1, mk(3, 0, 13, 0, 6'h00), 0, r);
        check("d_rdy_post", r, 1);
        check("d_ov_post", out_valid, 0);
        drive(0, '0, 0, r);
        check("d_drained", r, 1);
        check("d_ov_issue", out_valid, 1);
        check("d_stall_end", stall_count, 4);

        repeat (3) drive(0, '0, 0, r);
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
